// File: rtl/mem_ctl_backend.sv
// mem_ctl_backend: word-addressed storage behind a four-phase request/done
// handshake. A request is latched in IDLE, spends WAIT_CYCLES cycles in
// ACCESS and is then acknowledged from DONE until the request drops.
//
// Handshake: mem_write/mem_read are request levels. The upstream controller
// raises one of them and holds it, with addr/wdata, until mem_done rises. It
// then drops the request, and mem_done falls on the first edge that sees the
// request low. Dropping a request before mem_done rises aborts the operation
// and sets the sticky proto_err flag. Both requests high at once performs the
// write and also sets proto_err.
//
// Optional feature: define MEM_CTL_BACKEND_SYNC_EN to pass mem_write and
// mem_read through two-flop synchronizers. This adds 2 cycles to every
// request edge and release. Without it, the requests must already be
// synchronous to clk.
module mem_ctl_backend #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_done,
  output logic              proto_err
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic wr_s;
  logic rd_s;
  logic req;

  logic [CNT_W-1:0]  cnt;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] storage [2**ADDR_W];

  logic do_latch;
  logic do_exec;
  logic do_abort;
  logic do_dec;

`ifdef MEM_CTL_BACKEND_SYNC_EN
  logic [1:0] wr_sync;
  logic [1:0] rd_sync;

  // Two-flop synchronizers on both request levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sync <= '0;
      rd_sync <= '0;
    end else begin
      wr_sync <= {wr_sync[0], mem_write};
      rd_sync <= {rd_sync[0], mem_read};
    end
  end

  assign wr_s = wr_sync[1];
  assign rd_s = rd_sync[1];
`else
  assign wr_s = mem_write;
  assign rd_s = mem_read;
`endif

  assign req = wr_s | rd_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic and one-cycle datapath strobes.
  always_comb begin
    next_state = state;
    do_latch   = 1'b0;
    do_exec    = 1'b0;
    do_abort   = 1'b0;
    do_dec     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          do_latch   = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (!req) begin
          do_abort   = 1'b1;
          next_state = IDLE;
        end else if (cnt == '0) begin
          do_exec    = 1'b1;
          next_state = DONE;
        end else begin
          do_dec = 1'b1;
        end
      end
      DONE: begin
        // A request still high here, even of the other type, counts as the
        // same request: DONE is left only after req has been seen low.
        if (!req) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operation latch, wait counter, read data, acknowledge and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      mem_done  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (do_latch) begin
        op_wr   <= wr_s;
        addr_q  <= addr;
        wdata_q <= wdata;
        cnt     <= CNT_W'(WAIT_CYCLES - 1);
        if (wr_s && rd_s) proto_err <= 1'b1;
      end
      if (do_dec) cnt <= cnt - 1'b1;
      if (do_exec && !op_wr) rdata <= storage[addr_q];
      if (do_abort) proto_err <= 1'b1;
      mem_done <= (next_state == DONE);
    end
  end

  // Storage is not reset. A reset forces IDLE, so no write strobe can occur
  // while rst is high.
  always_ff @(posedge clk) begin
    if (do_exec && op_wr) storage[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_ctl_backend.sv
// Testbench for mem_ctl_backend. It works with or without
// MEM_CTL_BACKEND_SYNC_EN; the expected latencies follow the macro.
module tb_mem_ctl_backend;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int WAIT   = 2;
`ifdef MEM_CTL_BACKEND_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int DEPTH = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_done;
  logic              proto_err;

  mem_ctl_backend #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT)
  ) dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .mem_read(mem_read),
    .addr(addr), .wdata(wdata), .rdata(rdata), .mem_done(mem_done),
    .proto_err(proto_err)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  // Reference model: the storage array plus the visible output state.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] ref_rdata;
  logic              ref_err;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected read data in completion order.
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Full four-phase operation. Called at a negedge with both requests low.
  task automatic op(input logic wr, input logic rd,
                    input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int  n;
    bit  seen;
    mem_write = wr;
    mem_read  = rd;
    addr      = a;
    wdata     = d;
    if (wr) ref_mem[a] = d;
    else    exp_q.push_back(ref_mem[a]);
    if (wr && rd) ref_err = 1'b1;
    n = 0;
    seen = 0;
    while (n < 60 && !seen) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      // The operation is latched at edge SYNC+1; later changes must not matter.
      if (n == SYNC + 1) begin
        addr  = ADDR_W'($urandom);
        wdata = DATA_W'($urandom);
      end
      if (mem_done) seen = 1;
    end
    check("done_latency", seen ? n : 0, WAIT + 1 + SYNC);
    if (!wr) ref_rdata = exp_q.pop_front();
    check("rdata", 32'(rdata), 32'(ref_rdata));
    check("proto_err", 32'(proto_err), 32'(ref_err));
    mem_write = 1'b0;
    mem_read  = 1'b0;
    n = 0;
    seen = 0;
    while (n < 60 && !seen) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!mem_done) seen = 1;
    end
    check("release_latency", seen ? n : 0, 1 + SYNC);
  endtask

  // A read whose request is held for one sampled edge only, so it is
  // dropped after one ACCESS cycle.
  task automatic abort_read(input logic [ADDR_W-1:0] a);
    int highs;
    mem_read = 1'b1;
    addr     = a;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    ref_err  = 1'b1;
    highs = 0;
    for (int i = 0; i < 2 * SYNC + 8; i++) begin
      @(negedge clk);
      if (mem_done) highs++;
    end
    check("abort_done_never", highs, 0);
    check("abort_rdata", 32'(rdata), 32'(ref_rdata));
    check("abort_err", 32'(proto_err), 32'(ref_err));
  endtask

  // Stimulus.
  initial begin
    logic [DATA_W-1:0] v;
    logic              w;
    rst       = 1'b1;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    addr      = '0;
    wdata     = '0;
    ref_rdata = '0;
    ref_err   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(mem_done), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_err", 32'(proto_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Give every word a known value.
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, ADDR_W'(i), DATA_W'($urandom));

    // Directed write then read-back of address 3.
    op(1'b1, 1'b0, 4'd3, 8'hA5);
    op(1'b0, 1'b1, 4'd3, 8'h00);
    check("read3", 32'(rdata), 32'hA5);

    // Random writes and reads.
    for (int i = 0; i < 30; i++) begin
      w = 1'($urandom_range(0, 1));
      op(w, !w, ADDR_W'($urandom), DATA_W'($urandom));
    end

    // Reset during the ACCESS phase of a write to address 7.
    mem_write = 1'b1;
    addr      = 4'd7;
    wdata     = 8'hFF;
    repeat (SYNC + 2) @(negedge clk);
    #2 rst = 1'b1;
    ref_rdata = '0;
    ref_err   = 1'b0;
    #1;
    check("midrst_done", 32'(mem_done), 0);
    check("midrst_rdata", 32'(rdata), 0);
    check("midrst_err", 32'(proto_err), 0);
    mem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op(1'b0, 1'b1, 4'd7, 8'h00);

    // Both requests at once: the write wins and the error flag is set.
    op(1'b1, 1'b1, 4'd5, 8'h3C);
    op(1'b0, 1'b1, 4'd5, 8'h00);
    check("read5", 32'(rdata), 32'h3C);

    // Abort a read, then check the controller still works from IDLE.
    v = ref_rdata;
    abort_read(4'd2);
    check("abort_keeps_rdata", 32'(rdata), 32'(v));
    for (int i = 0; i < 10; i++) begin
      w = 1'($urandom_range(0, 1));
      op(w, !w, ADDR_W'($urandom), DATA_W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctl_backend.md
MEM_CTL_BACKEND -- requirements
Module: mem_ctl_backend

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning address width; storage depth 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8, meaning word width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2 (legal >=1), meaning cycles spent in ACCESS per operation.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port mem_write  input  1  write request level from upstream controller (four-phase).
REQ-007 SHALL have port mem_read  input  1  read request level from upstream controller (four-phase).
REQ-008 SHALL have port addr  input  ADDR_W  word address.
REQ-009 SHALL have port wdata  input  DATA_W  write data.
REQ-010 SHALL have port rdata  output  DATA_W  registered read data; valid while mem_done high after a read.
REQ-011 SHALL have port mem_done  output  1  registered completion acknowledge to upstream.
REQ-012 SHALL have port proto_err  output  1  sticky handshake-violation flag.

Function
REQ-013 SHALL implement a four-phase handshake: request rises -> mem_done rises; request falls -> mem_done falls.
REQ-014 SHALL use FSM states IDLE, ACCESS, DONE, encoded in a registered state vector.
REQ-015 SHALL, in IDLE with effective request req = wr_s|rd_s high, latch op (write if wr_s), addr and wdata at that edge and enter ACCESS.
REQ-016 SHALL remain in ACCESS exactly WAIT_CYCLES cycles, counted by a down-counter loaded with WAIT_CYCLES-1 on entry.
REQ-017 SHALL, at the ACCESS exit edge, write latched wdata to storage[latched addr] for writes, or load rdata from storage[latched addr] for reads, and enter DONE.
REQ-018 SHALL drive mem_done high in DONE only; rdata unchanged on writes.
REQ-019 SHALL, in DONE, return to IDLE on the first edge where req is low; mem_done low from that edge.
REQ-020 SHALL treat a request that reappears in DONE with the opposite type as still-held; no new operation until req has been low for one IDLE-entering edge.
REQ-021 SHALL, if both wr_s and rd_s are high when leaving IDLE, perform the write and set proto_err.
REQ-022 SHALL, if req falls during ACCESS, abort: no storage write, rdata unchanged, set proto_err, go to IDLE next edge, mem_done stays low.
REQ-023 SHALL hold proto_err high once set until rst.
REQ-024 SHALL ignore addr/wdata changes after the IDLE->ACCESS latch edge.
REQ-025 SHALL give latency (request-sampled edge to mem_done high) of WAIT_CYCLES+1 edges, plus synchronizer delay per REQ-030.

Reset
REQ-026 SHALL, on rst high, immediately force state IDLE, mem_done 0, rdata 0, proto_err 0, counter 0, synchronizer flops 0.
REQ-027 SHALL, on rst mid-ACCESS, discard the pending operation with no storage write.
REQ-028 SHALL not reset storage contents.
REQ-029 SHALL leave IDLE no earlier than the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL, with macro MEM_CTL_BACKEND_SYNC_EN defined, pass mem_write/mem_read through two-flop synchronizers (wr_s/rd_s), adding 2 cycles of latency to every request edge and release.
REQ-031 SHALL, without MEM_CTL_BACKEND_SYNC_EN, use wr_s=mem_write, rd_s=mem_read directly (upstream guaranteed synchronous to clk).

Verification
REQ-032 SHALL cover: no sync, WAIT_CYCLES=2, write addr 3 data 0xA5 -> mem_done high 3 edges after request sampled; drop request -> mem_done low next edge; proto_err 0.
REQ-033 SHALL cover: read addr 3 after REQ-032 write -> rdata 0xA5 with mem_done high.
REQ-034 SHALL cover: mem_write and mem_read both high, addr 5 data 0x3C -> storage[5]=0x3C, mem_done high, proto_err 1 and stays 1.
REQ-035 SHALL cover: read request dropped after 1 ACCESS cycle -> mem_done never high, rdata unchanged, proto_err 1, state IDLE.
REQ-036 SHALL cover: rst pulse mid-ACCESS of write addr 7 data 0xFF -> outputs 0 at once, storage[7] unchanged.
REQ-037 SHALL cover: with MEM_CTL_BACKEND_SYNC_EN, REQ-032 stimulus -> mem_done high 5 edges after request first sampled, low 3 edges after release.
